// File: rtl/arbitro_mux.sv
// Round-robin scheduler for a 4-to-1 FIFO merge mux with weighted bursts.
// Pops a source each cycle and drives the mux select/enable one cycle later.
module arbitro_mux #(
    parameter int PESO = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enb,
    input  logic [3:0] fifo_empty,
    input  logic       destino_full,
    output logic [3:0] pop,
    output logic [1:0] selector,
    output logic       mux_enb,
    output logic       estado
);

    typedef enum logic {
        IDLE     = 1'b0,
        SERVICIO = 1'b1
    } estado_t;

    generate
        if (PESO < 1 || PESO > 15) begin : g_peso_check
            $error("arbitro_mux: PESO must be in 1..15");
        end
    endgenerate

    estado_t    estado_q, estado_d;
    logic [1:0] grant_q, grant_d;
    logic [3:0] cuenta_q, cuenta_d;
    logic       puede;
    logic       continua;
    logic       hay;
    logic [1:0] cand;
    logic [1:0] rot;
    logic [1:0] pop_idx;

    // Rotation target: old grant is searched last so it only wins when alone.
    always_comb begin
        hay  = 1'b0;
        rot  = grant_q;
        cand = grant_q;
        for (int k = 1; k <= 4; k++) begin
            cand = grant_q + 2'(k);
            if (!hay && !fifo_empty[cand]) begin
                hay = 1'b1;
                rot = cand;
            end
        end
    end

    always_comb begin
        puede    = enb & ~reset & ~destino_full;
        continua = (estado_q == SERVICIO) && (cuenta_q < 4'(PESO)) && !fifo_empty[grant_q];
        pop      = 4'b0000;
        pop_idx  = grant_q;
        estado_d = estado_q;
        grant_d  = grant_q;
        cuenta_d = cuenta_q;
        if (puede) begin
            if (continua) begin
                pop[grant_q] = 1'b1;
                cuenta_d     = cuenta_q + 4'd1;
            end else if (hay) begin
                pop[rot] = 1'b1;
                pop_idx  = rot;
                grant_d  = rot;
                cuenta_d = 4'd1;
                estado_d = SERVICIO;
            end else begin
                estado_d = IDLE;
            end
        end
    end

    // Reset leaves grant at 3 so the first search starts at source 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= IDLE;
            grant_q  <= 2'd3;
            cuenta_q <= 4'd0;
            selector <= 2'd0;
            mux_enb  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            grant_q  <= grant_d;
            cuenta_q <= cuenta_d;
            mux_enb  <= |pop;
            if (|pop) begin
                selector <= pop_idx;
            end
        end
    end

    assign estado = estado_q;

endmodule

// File: tb/tb_arbitro_mux.sv
// Bench for arbitro_mux: cycle vectors for pop, scoreboard queue for the
// registered mux_enb/selector/estado outputs one cycle later.
module tb_arbitro_mux;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enb = 1'b1;
    logic [3:0] fifo_empty = 4'b1111;
    logic       destino_full = 1'b0;

    logic [3:0] pop4, pop2;
    logic [1:0] sel4, sel2;
    logic       menb4, menb2, est4, est2;

    always #5 clk = ~clk;

    arbitro_mux #(.PESO(4)) u_p4 (
        .clk(clk), .reset(reset), .enb(enb), .fifo_empty(fifo_empty),
        .destino_full(destino_full), .pop(pop4), .selector(sel4),
        .mux_enb(menb4), .estado(est4)
    );

    arbitro_mux #(.PESO(2)) u_p2 (
        .clk(clk), .reset(reset), .enb(enb), .fifo_empty(fifo_empty),
        .destino_full(destino_full), .pop(pop2), .selector(sel2),
        .mux_enb(menb2), .estado(est2)
    );

    typedef struct {
        bit         dut;      // 0: PESO=4 instance, 1: PESO=2 instance
        logic       rst;
        logic       en;
        logic [3:0] emp;
        logic       full;
        logic [3:0] exp_pop;
        logic       exp_est;  // estado after this cycle's edge
    } vec_t;

    typedef struct {
        bit         dut;
        logic       menb;
        logic [1:0] sel;
        logic       est;
    } exp_t;

    localparam logic I = 1'b0;
    localparam logic S = 1'b1;

    vec_t       vecs[$];
    exp_t       sb[$];
    int         nvec = 0;
    int         nmis = 0;
    int         cyc  = 0;
    logic [1:0] sel_hold = 2'd0;

    function automatic vec_t v(bit d, logic r, logic e, logic [3:0] emp, logic f,
                               logic [3:0] p, logic s);
        vec_t x;
        x.dut = d; x.rst = r; x.en = e; x.emp = emp; x.full = f;
        x.exp_pop = p; x.exp_est = s;
        return x;
    endfunction

    function automatic logic [1:0] idx(logic [3:0] p);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (p[i]) r = 2'(i);
        return r;
    endfunction

    task automatic chk(string nm, logic [3:0] act, logic [3:0] req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s cycle %0d: got %b, want %b", nm, cyc, act, req);
        end
    endtask

    task automatic step(input vec_t x);
        exp_t e, n;
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("mux_enb", {3'b0, e.dut ? menb2 : menb4}, {3'b0, e.menb});
            chk("selector", {2'b0, e.dut ? sel2 : sel4}, {2'b0, e.sel});
            chk("estado", {3'b0, e.dut ? est2 : est4}, {3'b0, e.est});
        end
        reset        = x.rst;
        enb          = x.en;
        fifo_empty   = x.emp;
        destino_full = x.full;
        #1;
        chk("pop", x.dut ? pop2 : pop4, x.exp_pop);
        if (x.rst) sel_hold = 2'd0;
        else if (|x.exp_pop) sel_hold = idx(x.exp_pop);
        n.dut  = x.dut;
        n.menb = |x.exp_pop;
        n.sel  = sel_hold;
        n.est  = x.exp_est;
        sb.push_back(n);
    endtask

    initial begin
        // Reset then release with everything non-empty: source 0 first.
        vecs.push_back(v(0, 1, 1, 4'b0000, 0, 4'b0000, I));
        vecs.push_back(v(0, 1, 1, 4'b0000, 0, 4'b0000, I));
        vecs.push_back(v(0, 0, 1, 4'b0000, 0, 4'b0001, S));
        vecs.push_back(v(0, 0, 1, 4'b0000, 0, 4'b0001, S));
        // Single source: FIFO2 holds 3 words, PESO=4.
        vecs.push_back(v(0, 1, 1, 4'b1111, 0, 4'b0000, I));
        vecs.push_back(v(0, 0, 1, 4'b1011, 0, 4'b0100, S));
        vecs.push_back(v(0, 0, 1, 4'b1011, 0, 4'b0100, S));
        vecs.push_back(v(0, 0, 1, 4'b1011, 0, 4'b0100, S));
        vecs.push_back(v(0, 0, 1, 4'b1111, 0, 4'b0000, I));
        vecs.push_back(v(0, 0, 1, 4'b1111, 0, 4'b0000, I));
        // Full load, PESO=2: 0,0,1,1,2,2,3,3,0,0.
        vecs.push_back(v(1, 1, 1, 4'b0000, 0, 4'b0000, I));
        vecs.push_back(v(1, 0, 1, 4'b0000, 0, 4'b0001, S));
        vecs.push_back(v(1, 0, 1, 4'b0000, 0, 4'b0001, S));
        vecs.push_back(v(1, 0, 1, 4'b0000, 0, 4'b0010, S));
        vecs.push_back(v(1, 0, 1, 4'b0000, 0, 4'b0010, S));
        vecs.push_back(v(1, 0, 1, 4'b0000, 0, 4'b0100, S));
        vecs.push_back(v(1, 0, 1, 4'b0000, 0, 4'b0100, S));
        vecs.push_back(v(1, 0, 1, 4'b0000, 0, 4'b1000, S));
        vecs.push_back(v(1, 0, 1, 4'b0000, 0, 4'b1000, S));
        vecs.push_back(v(1, 0, 1, 4'b0000, 0, 4'b0001, S));
        vecs.push_back(v(1, 0, 1, 4'b0000, 0, 4'b0001, S));
        // Early empty, PESO=4: FIFO0 one word, FIFO2 empty -> 0,1,1,1,1,3.
        vecs.push_back(v(0, 1, 1, 4'b0000, 0, 4'b0000, I));
        vecs.push_back(v(0, 0, 1, 4'b0100, 0, 4'b0001, S));
        vecs.push_back(v(0, 0, 1, 4'b0101, 0, 4'b0010, S));
        vecs.push_back(v(0, 0, 1, 4'b0101, 0, 4'b0010, S));
        vecs.push_back(v(0, 0, 1, 4'b0101, 0, 4'b0010, S));
        vecs.push_back(v(0, 0, 1, 4'b0101, 0, 4'b0010, S));
        vecs.push_back(v(0, 0, 1, 4'b0101, 0, 4'b1000, S));
        vecs.push_back(v(0, 0, 1, 4'b0101, 0, 4'b1000, S));

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // Backpressure, PESO=2: stall 3 cycles after first FIFO1 pop.
        step(v(1, 1, 1, 4'b0000, 0, 4'b0000, I));
        step(v(1, 0, 1, 4'b0000, 0, 4'b0001, S));
        step(v(1, 0, 1, 4'b0000, 0, 4'b0001, S));
        step(v(1, 0, 1, 4'b0000, 0, 4'b0010, S));
        step(v(1, 0, 1, 4'b0000, 1, 4'b0000, S));
        step(v(1, 0, 1, 4'b0000, 1, 4'b0000, S));
        step(v(1, 0, 1, 4'b0000, 1, 4'b0000, S));
        step(v(1, 0, 1, 4'b0000, 0, 4'b0010, S));
        step(v(1, 0, 1, 4'b0000, 0, 4'b0100, S));
        step(v(1, 0, 1, 4'b0000, 0, 4'b0100, S));
        step(v(1, 0, 1, 4'b0000, 0, 4'b1000, S));

        // Reset mid-burst: grant=2, cuenta=1, then reset with all non-empty.
        step(v(0, 1, 1, 4'b0000, 0, 4'b0000, I));
        step(v(0, 0, 1, 4'b0011, 0, 4'b0100, S));
        step(v(0, 1, 1, 4'b0000, 0, 4'b0000, I));
        step(v(0, 0, 1, 4'b0000, 0, 4'b0001, S));
        step(v(0, 0, 1, 4'b0000, 0, 4'b0001, S));

        // enb low mid-burst, PESO=4: count resumes, rotation after 4 pops.
        step(v(0, 1, 1, 4'b0000, 0, 4'b0000, I));
        step(v(0, 0, 1, 4'b0000, 0, 4'b0001, S));
        step(v(0, 0, 1, 4'b0000, 0, 4'b0001, S));
        step(v(0, 0, 0, 4'b0000, 0, 4'b0000, S));
        step(v(0, 0, 0, 4'b0000, 0, 4'b0000, S));
        step(v(0, 0, 1, 4'b0000, 0, 4'b0001, S));
        step(v(0, 0, 1, 4'b0000, 0, 4'b0001, S));
        step(v(0, 0, 1, 4'b0000, 0, 4'b0010, S));

        // Grant source empties when its quantum is used up: one rotation.
        step(v(1, 1, 1, 4'b0000, 0, 4'b0000, I));
        step(v(1, 0, 1, 4'b0000, 0, 4'b0001, S));
        step(v(1, 0, 1, 4'b0000, 0, 4'b0001, S));
        step(v(1, 0, 1, 4'b0001, 0, 4'b0010, S));
        step(v(1, 0, 1, 4'b0000, 0, 4'b0010, S));
        step(v(1, 0, 1, 4'b0000, 0, 4'b0100, S));

        // Drain the last scoreboard entry.
        step(v(0, 1, 1, 4'b1111, 0, 4'b0000, I));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
